pulse_stretcher: RTL

- Output-side counterpart to the button one-shot: turns single-cycle event strobes into fixed-width pulses that slow consumers can see, such as LEDs, relay/RIS driver strobes and UART status lines.
- Queues strobes that arrive while a pulse is in progress and replays them as back-to-back pulses, with a guaranteed low gap between them.
- Sits between the command/one-shot logic and the board output pins.

---
 rtl/pulse_stretcher.sv | 139 +++++++++++++
 1 files changed

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event strobes into fixed-width output pulses, queueing
// strobes that arrive mid-pulse and replaying them with a guaranteed low gap.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no pulse in progress, nothing queued
// HIGH  | pulse_out high, timer counts HIGH_CYCLES down to zero
// GAP   | pulse_out low, timer counts GAP_CYCLES; last cycle picks next
module pulse_stretcher #(
    parameter int HIGH_CYCLES = 5_000_000,
    parameter int GAP_CYCLES  = 2_500_000,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trig,
    input  logic             clr_ovf,
    output logic             pulse_out,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
);

    localparam int MAX_CYC = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);

    localparam logic [TMR_W-1:0] HIGH_LOAD = TMR_W'(HIGH_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PEND_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_GAP
    } state_t;

    state_t             state_q,    state_d;
    logic [TMR_W-1:0]   timer_q,    timer_d;
    logic [CNT_W-1:0]   pending_q,  pending_d;
    logic               overflow_q, overflow_d;
    logic               pulse_q,    pulse_d;
    logic               busy_q,     busy_d;

    logic tmr_done;
    logic work;
    logic queue_trig;
    logic drop;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;
        drop       = 1'b0;
        queue_trig = 1'b0;
        tmr_done   = (timer_q == '0);
        work       = (pending_q != '0) | trig;

        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    state_d = ST_HIGH;
                    timer_d = HIGH_LOAD;
                end
            end
            ST_HIGH: begin
                queue_trig = trig;
                if (tmr_done) begin
                    state_d = ST_GAP;
                    timer_d = GAP_LOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (tmr_done) begin
                    // A trig here is consumed directly, so pending never grows
                    if (work) begin
                        state_d = ST_HIGH;
                        timer_d = HIGH_LOAD;
                        if (!trig) begin
                            pending_d = pending_q - 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    queue_trig = trig;
                    timer_d    = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase

        if (queue_trig) begin
            if (pending_q == PEND_MAX) begin
                drop = 1'b1;
            end else begin
                pending_d = pending_q + 1'b1;
            end
        end

        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end

        pulse_d = (state_d == ST_HIGH);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            pulse_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            pulse_q    <= pulse_d;
            busy_q     <= busy_d;
        end
    end

    assign pulse_out = pulse_q;
    assign busy      = busy_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule
